// File: rtl/mem_interface.sv
// Bridges the multicycle control unit to a single-port word memory bus:
// lane generation, load extraction/extension, and a three-state bus handshake.
module mem_interface #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  fetch,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            f3,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  mem_complete,
  output logic                  misaligned,
  output logic                  access_fault,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [3:0]            bus_be,
  output logic [31:0]           bus_wdata,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [1:0]  SIZE_BYTE  = 2'b00;
  localparam logic [1:0]  SIZE_HALF  = 2'b01;
  localparam logic [1:0]  SIZE_WORD  = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [1:0]            size_c;
  logic                  request_c;
  logic [3:0]            be_c;
  logic [DATA_WIDTH-1:0] lane_wdata_c;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  zext_q;
  logic [DATA_WIDTH-1:0] shifted_c;
  logic [DATA_WIDTH-1:0] load_c;

  assign size_c    = fetch ? SIZE_WORD : f3[1:0];
  assign request_c = mem_read | mem_write;

  // Alignment/legality check, zero latency for the exception path.
  always_comb begin
    misaligned = 1'b0;
    if (request_c) begin
      unique case (size_c)
        SIZE_BYTE: misaligned = 1'b0;
        SIZE_HALF: misaligned = addr[0];
        SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
        default:   misaligned = 1'b1;
      endcase
    end
  end

  // Byte enables and lane-aligned store data for the current request.
  always_comb begin
    unique case (size_c)
      SIZE_BYTE: be_c = 4'b0001;
      SIZE_HALF: be_c = 4'b0011;
      default:   be_c = 4'b1111;
    endcase
    be_c         = be_c << addr[1:0];
    lane_wdata_c = wdata << {addr[1:0], 3'b000};
  end

  // Load extraction uses the operands captured at request acceptance.
  always_comb begin
    shifted_c = bus_rdata >> {off_q, 3'b000};
    unique case (size_q)
      SIZE_BYTE: load_c = {{24{~zext_q & shifted_c[7]}}, shifted_c[7:0]};
      SIZE_HALF: load_c = {{16{~zext_q & shifted_c[15]}}, shifted_c[15:0]};
      default:   load_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rdata        <= '0;
      mem_complete <= 1'b0;
      access_fault <= 1'b0;
      bus_addr     <= '0;
      bus_read     <= 1'b0;
      bus_write    <= 1'b0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      off_q        <= '0;
      size_q       <= '0;
      zext_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (request_c && !misaligned) begin
            bus_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            bus_be    <= mem_write ? be_c : 4'hF;
            bus_wdata <= lane_wdata_c;
            bus_write <= mem_write;
            bus_read  <= ~mem_write;
            off_q     <= addr[1:0];
            size_q    <= size_c;
            zext_q    <= f3[2] | fetch;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus_ack) begin
            rdata        <= bus_err ? '0 : load_c;
            access_fault <= bus_err;
            mem_complete <= 1'b1;
            bus_read     <= 1'b0;
            bus_write    <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: begin
          mem_complete <= 1'b0;
          access_fault <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: fetch, loads, stores with wait states,
// misalignment, bus error, back-to-back issue and asynchronous reset.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, fetch;
  logic [31:0] addr;
  logic [2:0]  f3;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_complete, misaligned, access_fault;
  logic [31:0] bus_addr;
  logic        bus_read, bus_write;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_interface #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .fetch(fetch), .addr(addr), .f3(f3), .wdata(wdata), .rdata(rdata),
    .mem_complete(mem_complete), .misaligned(misaligned),
    .access_fault(access_fault), .bus_addr(bus_addr), .bus_read(bus_read),
    .bus_write(bus_write), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted access: request at cycle 0, strobe at cycle 1, ack after
  // `waits` extra cycles, completion one cycle after ack. Returns at DONE+1.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic f, input logic [31:0] a, input logic [2:0] fn,
                            input logic [31:0] wd, input logic [31:0] rdb,
                            input int waits, input logic err,
                            input logic [31:0] exp_addr, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_rdata);
    mem_read = rd; mem_write = wr; fetch = f; addr = a; f3 = fn; wdata = wd;
    #1;
    check({tag, ".misaligned"}, 32'(misaligned), 32'd0);
    tick();
    check({tag, ".bus_read"}, 32'(bus_read), 32'(rd & ~wr));
    check({tag, ".bus_write"}, 32'(bus_write), 32'(wr));
    check({tag, ".bus_addr"}, bus_addr, exp_addr);
    check({tag, ".bus_be"}, 32'(bus_be), 32'(exp_be));
    if (wr) check({tag, ".bus_wdata"}, bus_wdata, exp_wd);
    // Operand changes while busy must not disturb the transfer.
    addr = 32'h0000_0FFF; f3 = 3'b111; wdata = 32'h5555_5555;
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, ".held_strobe"}, 32'(bus_read | bus_write), 32'd1);
      check({tag, ".held_addr"}, bus_addr, exp_addr);
      check({tag, ".early_complete"}, 32'(mem_complete), 32'd0);
    end
    bus_ack = 1'b1; bus_err = err; bus_rdata = rdb;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'hCCCC_CCCC;
    check({tag, ".mem_complete"}, 32'(mem_complete), 32'd1);
    check({tag, ".access_fault"}, 32'(access_fault), 32'(err));
    check({tag, ".strobe_drop"}, 32'(bus_read | bus_write), 32'd0);
    if (rd & ~wr) check({tag, ".rdata"}, rdata, exp_rdata);
    // Request still held during DONE is ignored.
    tick();
    check({tag, ".complete_pulse"}, 32'(mem_complete), 32'd0);
    check({tag, ".fault_pulse"}, 32'(access_fault), 32'd0);
    check({tag, ".no_reissue"}, 32'(bus_read | bus_write), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0; fetch = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 0; mem_write = 0; fetch = 0; addr = 0; f3 = 0; wdata = 0;
    bus_rdata = 0; bus_ack = 0; bus_err = 0;
    tick(); tick();
    check("reset.rdata", rdata, 32'd0);
    check("reset.outs", {26'd0, mem_complete, access_fault, bus_read, bus_write, 2'b00}, 32'd0);
    check("reset.bus_be", 32'(bus_be), 32'd0);
    rst = 1'b0;
    tick();

    run_access("fetch", 1, 0, 1, 32'h100, 3'b001, 0, 32'h0050_0093, 0, 0,
               32'h100, 4'hF, 0, 32'h0050_0093);
    run_access("lb", 1, 0, 0, 32'h203, 3'b000, 0, 32'h80FF_FFFF, 0, 0,
               32'h200, 4'hF, 0, 32'hFFFF_FF80);
    run_access("lbu", 1, 0, 0, 32'h203, 3'b100, 0, 32'h80FF_FFFF, 1, 0,
               32'h200, 4'hF, 0, 32'h0000_0080);
    run_access("sh", 0, 1, 0, 32'h302, 3'b001, 32'h1234_ABCD, 0, 3, 0,
               32'h300, 4'hC, 32'hABCD_0000, 0);

    // Misaligned and illegal requests never reach the bus.
    mem_read = 1; addr = 32'h401; f3 = 3'b010;
    #1 check("mis.word", 32'(misaligned), 32'd1);
    addr = 32'h400; f3 = 3'b011;
    #1 check("mis.illegal", 32'(misaligned), 32'd1);
    f3 = 3'b001; addr = 32'h401;
    #1 check("mis.half", 32'(misaligned), 32'd1);
    mem_read = 0;
    #1 check("mis.noreq", 32'(misaligned), 32'd0);
    mem_read = 1; addr = 32'h401; f3 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mis.no_strobe", 32'(bus_read | bus_write), 32'd0);
      check("mis.no_complete", 32'(mem_complete), 32'd0);
    end
    mem_read = 0;
    tick();

    // Bus error, then immediate back-to-back accesses.
    run_access("err", 1, 0, 0, 32'h500, 3'b010, 0, 32'hDEAD_BEEF, 0, 1,
               32'h500, 4'hF, 0, 32'd0);
    run_access("lh_b2b", 1, 0, 0, 32'h502, 3'b001, 0, 32'h8001_1234, 0, 0,
               32'h500, 4'hF, 0, 32'hFFFF_8001);
    run_access("rw_sb", 1, 1, 0, 32'h601, 3'b000, 32'h0000_00AB, 0, 0, 0,
               32'h600, 4'h2, 32'h0000_AB00, 0);

    // Asynchronous reset while waiting for ack.
    mem_read = 1; addr = 32'h700; f3 = 3'b010;
    tick();
    check("rst.pre_strobe", 32'(bus_read), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst.async_read", 32'(bus_read), 32'd0);
    check("rst.async_addr", bus_addr, 32'd0);
    mem_read = 0;
    tick();
    rst = 1'b0;
    tick();
    run_access("fetch2", 1, 0, 1, 32'h104, 3'b000, 0, 32'h0000_0013, 0, 0,
               32'h104, 4'hF, 0, 32'h0000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute runtime bound.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_interface.md
# mem_interface

Bridges the core's multicycle control unit to the external single-port memory bus. It accepts level-held read/write requests (instruction fetch, load, store) from control and runs the bus handshake. It generates byte lanes and aligned store data, returns aligned and sign- or zero-extended load data, and signals `mem_complete` back to the microprogram sequencer. Misaligned accesses are flagged combinationally for the exception logic and never reach the bus.

## Interface
- `ADDR_WIDTH`, default 32: address width in bits; bus addresses are word-aligned.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: read request; held until `mem_complete`.
- `mem_write` in 1: write request; held until `mem_complete`.
- `fetch` in 1: the current access is an instruction fetch and is forced to word size.
- `addr` in ADDR_WIDTH: byte address, either PC or ALU result.
- `f3` in 3: access size, where [1:0] is 00 byte, 01 half, 10 word, 11 illegal; [2] set means zero-extend.
- `wdata` in 32: store data (rs2), right-justified.
- `rdata` out 32: extended load data; valid on the `mem_complete` cycle and held until the next completion.
- `mem_complete` out 1: one-cycle pulse, access finished.
- `misaligned` out 1: combinational; the requested access is misaligned or illegal.
- `access_fault` out 1: pulses together with `mem_complete` when the bus reported an error.
- `bus_addr` out ADDR_WIDTH: word address; bits [1:0] are always 0.
- `bus_read`, `bus_write` out 1: registered request strobes, held until `bus_ack`.
- `bus_be` out 4: byte enables; all 1s for reads.
- `bus_wdata` out 32: lane-aligned store data.
- `bus_rdata` in 32: read data, sampled when `bus_ack` is high.
- `bus_ack` in 1: transfer done.
- `bus_err` in 1: error qualifier, valid with `bus_ack`.

## Operation
- **Effective size.** Word when `fetch` is high, otherwise `f3[1:0]`.
- **`misaligned` rule.** Asserted while `mem_read | mem_write` and any of the following holds:
  - half access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0;
  - size = 11.
- **Lane generation.** `bus_be` = (1, 3 or F for byte, half, word) << `addr[1:0]`. `bus_wdata` = `wdata` << (8·`addr[1:0]`).
- **Load extraction.** Shift `bus_rdata` right by 8·`addr[1:0]`, then sign- or zero-extend per size and `f3[2]`. A fetch is never extended.
- **State machine.** Three states: IDLE, BUSY, DONE.
  - IDLE: when a request is present and `misaligned` = 0, register `bus_addr`, `bus_be`, `bus_wdata` and the strobe, then go to BUSY. If `misaligned` = 1, stay in IDLE with no bus activity.
  - BUSY: hold all bus outputs. On `bus_ack`, capture extended data into `rdata` (or 0 if `bus_err`), latch the fault, drop the strobes and go to DONE.
  - DONE: pulse `mem_complete` (and `access_fault` if latched). Return to IDLE unconditionally. The request still asserted in this cycle is ignored.
- **Simultaneous `mem_read` and `mem_write`.** Write wins. `bus_be` is still computed from the size.
- **Operand capture.** `addr`, `f3` and `wdata` are captured at IDLE→BUSY. Later changes are ignored until DONE.
- **Request dropped while BUSY.** The bus transfer still completes and DONE still pulses. Control discards the result.
- **Reset.** Asynchronous, to IDLE. All outputs go to 0 immediately: `rdata`, `bus_*`, `mem_complete`, `access_fault`.

## Timing
- A request seen in IDLE at cycle 0 raises `bus_read`/`bus_write` at cycle 1.
- With `bus_ack` at cycle 1, `mem_complete` is high at cycle 2. Minimum latency is 2 cycles; each wait state adds 1.
- A new request may be accepted in the cycle after DONE, giving a back-to-back throughput of one access per 3 cycles with zero wait states.
- `bus_ack` in IDLE or DONE is ignored.
- `misaligned` has zero latency (combinational from inputs) so that the control `exception` path can act in the same cycle.

## Test plan
- **Fetch:** `fetch`=1, `mem_read`=1, `addr`=0x100, `f3`=3'b001, `bus_rdata`=0x00500093, `bus_ack` at cycle 1 → `bus_addr`=0x100, `bus_be`=F, `mem_complete` at cycle 2, `rdata`=0x00500093.
- **Load byte, signed then unsigned:** `addr`=0x203, `f3`=000, `bus_rdata`=0x80FFFFFF → `rdata`=0xFFFFFF80. Repeat with `f3`=100 → `rdata`=0x00000080.
- **Store half with 3 wait states:** `addr`=0x302, `wdata`=0x1234ABCD, `f3`=001 → `bus_be`=C, `bus_wdata`=0xABCD0000. `bus_write` stays held while `bus_ack`=0. `mem_complete` arrives exactly 1 cycle after `bus_ack`.
- **Misaligned:** word read at `addr`=0x401 and `f3`=011 at 0x400 → `misaligned`=1 in the same cycle. No bus strobe for 5 cycles; `mem_complete` stays 0.
- **Bus error and back-to-back:** `bus_err` with `bus_ack` → `access_fault` and `mem_complete` pulse together, `rdata`=0. The next request issued at DONE+1 reaches the bus at DONE+2.
- **Reset mid-BUSY:** assert `rst` asynchronously while waiting → `bus_read`=0 before the next clock edge. After release the block is in IDLE and accepts a new fetch normally.
